// File: rtl/ahb_sram_banked.sv
// AHB-Lite memory slave over a byte-lane SRAM with optional read wait states,
// ERROR responses for bad transfers and write-to-read forwarding.
module ahb_sram_banked #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic                  hready,
  input  logic                  hwrite,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [31:0]           haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [1:0]            hresp,
  output logic                  hready_resp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int L     = $clog2(LANES);
  localparam int IDX_W = ADDR_WIDTH - L;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] WS_LOAD    = 2'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic                   hready_resp_q;
  logic [1:0]             hresp_q;
  logic [DATA_WIDTH-1:0]  hrdata_q;
  logic [DATA_WIDTH-1:0]  rd_buf_q;
  logic                   wr_pend_q;
  logic [IDX_W-1:0]       wr_addr_q;
  logic [LANES-1:0]       wr_strb_q;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   accept;
  logic                   addr_err;
  logic                   size_err;
  logic                   align_err;
  logic                   req_err;
  logic [7:0]             size_mask;
  logic [IDX_W-1:0]       rd_idx;
  logic [LANES-1:0]       strb;
  logic                   wr_commit;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   unused_sig;

  assign accept    = hsel & hready & htrans[1];
  assign addr_err  = |haddr[31:ADDR_WIDTH];
  assign size_err  = int'(hsize) > L;
  assign size_mask = (8'd1 << hsize) - 8'd1;
  assign align_err = |(haddr[7:0] & size_mask);
  assign req_err   = addr_err | size_err | align_err;
  assign rd_idx    = haddr[ADDR_WIDTH-1:L];
  assign wr_commit = wr_pend_q & hready_resp_q;
  assign unused_sig = ^{hburst, htrans[0]};

  always_comb begin
    strb = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(haddr[L-1:0]) && i < int'(haddr[L-1:0]) + (1 << hsize)) begin
        strb[i] = 1'b1;
      end
    end
  end

  // A write committing on the accepting edge supplies its strobed lanes directly.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_commit && (wr_addr_q == rd_idx)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb_q[i]) begin
          rd_word[i*8 +: 8] = hwdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_strb_q[i]) begin
          mem_q[wr_addr_q][i*8 +: 8] <= hwdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      hready_resp_q <= 1'b1;
      hresp_q       <= RESP_OKAY;
      hrdata_q      <= '0;
      rd_buf_q      <= '0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_strb_q     <= '0;
    end else begin
      wr_pend_q <= 1'b0;
      case (state_q)
        // ERR2 ends the error response with hready_resp=1, so it takes a new transfer
        ST_IDLE, ST_ERR2: begin
          state_q       <= ST_IDLE;
          hready_resp_q <= 1'b1;
          hresp_q       <= RESP_OKAY;
          if (accept) begin
            if (req_err) begin
              state_q       <= ST_ERR1;
              hready_resp_q <= 1'b0;
              hresp_q       <= RESP_ERROR;
            end else if (hwrite) begin
              wr_pend_q <= 1'b1;
              wr_addr_q <= rd_idx;
              wr_strb_q <= strb;
            end else if (WAIT_STATES == 0) begin
              hrdata_q <= rd_word;
            end else begin
              state_q       <= ST_RD_WAIT;
              cnt_q         <= WS_LOAD;
              hready_resp_q <= 1'b0;
              rd_buf_q      <= rd_word;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == 2'd1) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            hready_resp_q <= 1'b1;
            hrdata_q      <= rd_buf_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_ERR1: begin
          state_q       <= ST_ERR2;
          hready_resp_q <= 1'b1;
          hresp_q       <= RESP_ERROR;
        end
        default: begin
          state_q       <= ST_IDLE;
          hready_resp_q <= 1'b1;
          hresp_q       <= RESP_OKAY;
        end
      endcase
    end
  end

  assign hresp       = hresp_q;
  assign hready_resp = hready_resp_q;
  assign hrdata      = hrdata_q;

endmodule

// File: doc/ahb_sram_banked.md
# ahb_sram_banked

Parametrised AHB-Lite slave with on-chip byte-lane SRAM: configurable bus width, memory size and read wait states. Adds byte-strobed sub-word writes, ERROR responses for out-of-range, misaligned or oversize transfers, and read-after-write forwarding. Sits behind the AHB decoder as a drop-in memory slave.

## Interface
- DATA_WIDTH, 32: bus and memory word width; 32 or 64. Lanes = DATA_WIDTH/8.
- ADDR_WIDTH, 14: byte-address bits decoded; memory size = 2^ADDR_WIDTH bytes.
- WAIT_STATES, 0: extra read data-phase cycles, 0..3. Writes always have zero wait states.

Ports:
- hclk  in  1  clock; all logic on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- hready  in  1  bus ready; address phase sampled only when 1.
- hwrite  in  1  1 = write.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  in  3  transfer size, log2(bytes).
- hburst  in  3  accepted and ignored; each beat is handled as a single transfer.
- haddr  in  32  byte address.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hresp  out  2  OKAY=00, ERROR=01.
- hready_resp  out  1  data-phase complete.
- hrdata  out  DATA_WIDTH  read data.

## Operation
- **Accept:** hsel & hready & htrans[1].
  - IDLE/BUSY or hsel=0: zero-wait OKAY data phase, no memory access.
- **Error:** any of the following gives a two-cycle ERROR with no memory access:
  - haddr[31:ADDR_WIDTH] != 0;
  - 2^hsize > DATA_WIDTH/8;
  - haddr not aligned to 2^hsize.
- **Byte strobes:** lanes haddr[L-1:0] .. haddr[L-1:0]+2^hsize-1, where L = log2(DATA_WIDTH/8).
- **Write:**
  - Address phase registers word address, strobes and hwrite.
  - At the first hready_resp=1 edge of the data phase, hwdata lanes with strobe set are written. Other lanes are unchanged.
- **Read:**
  - Memory read issued at the accepting edge using haddr word index. Full word is returned regardless of hsize.
  - hrdata is registered, updated only when read data is returned, and holds its value otherwise.
- **Forwarding:** if a write commits on the same edge a read to the same word is accepted, hrdata returns the merged word: strobed lanes from hwdata, others from memory.
- **FSM states:**
  - IDLE: no pending wait.
  - RD_WAIT: counter from WAIT_STATES down to 1.
  - ERR1
  - ERR2
- **FSM transitions:**
  - Accepted read, WAIT_STATES>0 -> RD_WAIT.
  - Error access -> ERR1 -> ERR2 -> IDLE.
  - RD_WAIT reaches 1 -> IDLE. hready_resp=1 in the final cycle.
  - A transfer presented during ERR2 or the last RD_WAIT cycle (hready=1) is accepted normally.
- **Reset:**
  - Applies immediately; outstanding transfer is abandoned.
  - Memory contents are not cleared. Memory is undefined at power-up.

## Timing
- Reset values: hready_resp=1, hresp=00, hrdata=0, FSM=IDLE, wait counter=0.
- Write: data phase 1 cycle. Data readable by a read accepted at the same edge (forwarded) or later.
- Read: data phase 1+WAIT_STATES cycles.
  - hready_resp=0 for the first WAIT_STATES cycles.
  - hrdata valid in the cycle hready_resp=1.
- ERROR:
  - Cycle 1: hresp=01, hready_resp=0.
  - Cycle 2: hresp=01, hready_resp=1.
- OKAY is returned in all other cycles.
- Back-to-back NONSEQ/SEQ at zero wait: one transfer per cycle, no bubbles.
- Address-phase signals are ignored while hready=0; the pending data phase continues unaffected.

## Test plan
- **Word write/read (DATA_WIDTH=32, WAIT_STATES=0):**
  - Stimulus: write 0xDEADBEEF @0x100, then read @0x100.
  - Required: hrdata=0xDEADBEEF, hready_resp never 0, hresp=00.
- **Byte/halfword strobes:**
  - Stimulus: write word 0x11223344 @0x40, byte 0xAA @0x41 (hwdata=0x0000AA00), halfword 0xBBCC @0x42 (hwdata=0xBBCC0000), read @0x40.
  - Required: hrdata=0xBBCCAA44.
- **Forwarding:**
  - Stimulus: write 0x12345678 @0x20, then back-to-back read @0x20 accepted on the write's data-phase edge.
  - Required: hrdata=0x12345678 with no extra wait.
- **Errors:**
  - Stimulus: read @0x4000 (ADDR_WIDTH=14); halfword write @0x3; hsize=3 on a 32-bit bus.
  - Required per access: two cycles hresp=01 with hready_resp 0 then 1; memory unchanged on read-back.
- **Wait states (WAIT_STATES=2):**
  - Stimulus: three back-to-back reads.
  - Required: each data phase hready_resp=0,0,1; correct data per read; a following write completes in 1 cycle.
- **Reset mid-transfer:**
  - Stimulus: assert hreset during RD_WAIT.
  - Required: immediate hready_resp=1, hresp=00, hrdata=0; previously written data still readable after reset release.
